// File: rtl/mux_n_1_arb_pkg.sv
// Shared types for the registered N:1 multiplexer: operating mode and output-register state.
package mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mux_mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } mux_state_e;

endpackage : mux_pkg

// File: rtl/mux_n_1_arb_if.sv
// Handshake/bus bundle between N producer channels, the consumer and the multiplexer.
//   slave  : the multiplexer (takes channel data/valid and consumer ready, drives ack and output word)
//   master : the environment (producers + consumer)
// Signals:
//   Enable_In       1                  allow new loads
//   Mode_In         1                  0 = MANUAL, 1 = SCAN
//   Select_In       SEL_WIDTH          channel chosen in MANUAL mode
//   Data_In         NUM_CH*DATA_WIDTH  flattened channel data, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   Valid_In        NUM_CH             per-channel valid
//   Ack_Out         NUM_CH             one-hot, combinational, channel loaded this cycle
//   Ready_In        1                  consumer ready
//   MUX_Data_Out    DATA_WIDTH         registered output word
//   MUX_Valid_Out   1                  output register holds an unconsumed word
//   MUX_Channel_Out SEL_WIDTH          channel index of the held word
//   Sel_Err_Out     1                  registered pulse for an out-of-range MANUAL select
interface mux_n_1_arb_if #(
    parameter int unsigned NUM_CH     = 32,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned SEL_WIDTH = $clog2(NUM_CH);

    logic                         Enable_In;
    logic                         Mode_In;
    logic [SEL_WIDTH-1:0]         Select_In;
    logic [NUM_CH*DATA_WIDTH-1:0] Data_In;
    logic [NUM_CH-1:0]            Valid_In;
    logic [NUM_CH-1:0]            Ack_Out;
    logic                         Ready_In;
    logic [DATA_WIDTH-1:0]        MUX_Data_Out;
    logic                         MUX_Valid_Out;
    logic [SEL_WIDTH-1:0]         MUX_Channel_Out;
    logic                         Sel_Err_Out;

    modport slave (
        input  Enable_In, Mode_In, Select_In, Data_In, Valid_In, Ready_In,
        output Ack_Out, MUX_Data_Out, MUX_Valid_Out, MUX_Channel_Out, Sel_Err_Out
    );

    modport master (
        output Enable_In, Mode_In, Select_In, Data_In, Valid_In, Ready_In,
        input  Ack_Out, MUX_Data_Out, MUX_Valid_Out, MUX_Channel_Out, Sel_Err_Out
    );

endinterface : mux_n_1_arb_if

// File: rtl/mux_n_1_arb_rr_arbiter.sv
// Rotating-priority channel search: first valid channel at or after Pointer_In, wrapping modulo NUM_CH.
//   Valid_In    in   NUM_CH      per-channel request
//   Pointer_In  in   SEL_WIDTH   highest-priority channel this cycle (< NUM_CH)
//   Grant_Valid out  1           at least one channel requesting
//   Grant_Index out  SEL_WIDTH   winning channel
module rr_arbiter #(
    parameter int unsigned NUM_CH = 32
) (
    input  logic [NUM_CH-1:0]            Valid_In,
    input  logic [$clog2(NUM_CH)-1:0]    Pointer_In,
    output logic                         Grant_Valid,
    output logic [$clog2(NUM_CH)-1:0]    Grant_Index
);
    localparam int unsigned SEL_WIDTH = $clog2(NUM_CH);
    // One extra bit addresses the doubled request vector (2*NUM_CH <= 2**(SEL_WIDTH+1)).
    localparam int unsigned POS_WIDTH = SEL_WIDTH + 1;

    logic [2*NUM_CH-1:0]  req_dbl;
    logic                 hit;
    logic [POS_WIDTH-1:0] pos;

    assign req_dbl = {Valid_In, Valid_In};

    // Lowest set bit of the doubled vector at or above the pointer; descending scan keeps the lowest.
    always_comb begin
        hit = 1'b0;
        pos = '0;
        for (int i = 2*NUM_CH-1; i >= 0; i--) begin
            if (req_dbl[i] && (i >= int'(Pointer_In))) begin
                hit = 1'b1;
                pos = POS_WIDTH'(i);
            end
        end
    end

    // Fold the upper copy back onto channel numbers.
    assign Grant_Valid = hit;
    assign Grant_Index = (pos >= POS_WIDTH'(NUM_CH)) ? SEL_WIDTH'(pos - POS_WIDTH'(NUM_CH))
                                                     : SEL_WIDTH'(pos);

endmodule : rr_arbiter

// File: rtl/mux_n_1_arb.sv
// Registered N:1 multiplexer with per-channel valid, one-hot ack and downstream ready handshake.
// MANUAL mode loads the channel named by Select_In; SCAN mode round-robins over valid channels.
//   Clock_In    in  1    rising-edge clock
//   Reset_N_In  in  1    asynchronous active-low reset
//   bus         slave modport of mux_n_1_arb_if (channel inputs, consumer ready, output word, ack, error)
module mux_n_1_arb
    import mux_pkg::*;
#(
    parameter int unsigned NUM_CH     = 32,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic          Clock_In,
    input  logic          Reset_N_In,
    mux_n_1_arb_if.slave  bus
);
    localparam int unsigned SEL_WIDTH = $clog2(NUM_CH);

    mux_state_e            state_q, state_d;
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [SEL_WIDTH-1:0]  chan_q;
    logic                  sel_err_q;

    logic                  valid_q;
    logic                  mode_scan;
    logic                  can_load;
    logic                  consume;
    logic                  sel_in_range;
    logic                  man_valid;
    logic                  grant_valid;
    logic [SEL_WIDTH-1:0]  grant_index;
    logic                  load;
    logic [SEL_WIDTH-1:0]  load_idx;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  sel_err_d;
    logic [NUM_CH-1:0]     ack;

    // Rotating-priority search for SCAN mode.
    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .Valid_In    (bus.Valid_In),
        .Pointer_In  (ptr_q),
        .Grant_Valid (grant_valid),
        .Grant_Index (grant_index)
    );

    // Handshake qualifiers; a held word can be replaced in the cycle it is consumed.
    assign valid_q      = (state_q == ST_FULL);
    assign mode_scan    = (mux_mode_e'(bus.Mode_In) == MODE_SCAN);
    assign consume      = valid_q && bus.Ready_In;
    assign can_load     = bus.Enable_In && (!valid_q || bus.Ready_In);
    // Compared at 32 bits so a power-of-two NUM_CH does not alias to zero.
    assign sel_in_range = 32'(bus.Select_In) < NUM_CH;

    // Valid of the manually selected channel; out-of-range selects read as not valid.
    always_comb begin
        man_valid = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (bus.Select_In == SEL_WIDTH'(i)) begin
                man_valid = bus.Valid_In[i];
            end
        end
    end

    // Load decision and source channel.
    always_comb begin
        load_idx  = mode_scan ? grant_index : bus.Select_In;
        load      = can_load && (mode_scan ? grant_valid : (sel_in_range && man_valid));
        sel_err_d = !mode_scan && bus.Enable_In && !sel_in_range;
    end

    // Data select for the loaded channel.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (load_idx == SEL_WIDTH'(i)) begin
                load_data = bus.Data_In[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // One-hot ack on the channel loaded this cycle; forced low while reset is asserted.
    always_comb begin
        ack = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            ack[i] = load && Reset_N_In && (load_idx == SEL_WIDTH'(i));
        end
    end

    // Output-register FSM and scan pointer next state.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (consume && !load) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        // Only SCAN loads advance the pointer; MANUAL leaves it for the next scan.
        if (load && mode_scan) begin
            ptr_d = (grant_index == SEL_WIDTH'(NUM_CH - 1)) ? '0
                                                             : grant_index + SEL_WIDTH'(1);
        end
    end

    // State, pointer and output registers.
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q   <= ST_EMPTY;
            ptr_q     <= '0;
            data_q    <= '0;
            chan_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_err_q <= sel_err_d;
            if (load) begin
                data_q <= load_data;
                chan_q <= load_idx;
            end
        end
    end

    assign bus.Ack_Out         = ack;
    assign bus.MUX_Data_Out    = data_q;
    assign bus.MUX_Valid_Out   = valid_q;
    assign bus.MUX_Channel_Out = chan_q;
    assign bus.Sel_Err_Out     = sel_err_q;

endmodule : mux_n_1_arb

// File: tb/tb_mux_n_1_arb.sv
// Directed bench for mux_n_1_arb: a 5-channel/8-bit instance and a 32-channel/1-bit instance.
module tb_mux_n_1_arb;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mux_n_1_arb_if #(.NUM_CH(5),  .DATA_WIDTH(8)) bus();
    mux_n_1_arb_if #(.NUM_CH(32), .DATA_WIDTH(1)) bus2();

    mux_n_1_arb #(.NUM_CH(5), .DATA_WIDTH(8)) dut (
        .Clock_In   (clk),
        .Reset_N_In (rst_n),
        .bus        (bus.slave)
    );

    mux_n_1_arb #(.NUM_CH(32), .DATA_WIDTH(1)) dut32 (
        .Clock_In   (clk),
        .Reset_N_In (rst_n),
        .bus        (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [2:0] ch, input logic v);
        chk({tag, ".data"},  64'(bus.MUX_Data_Out),    64'(d));
        chk({tag, ".chan"},  64'(bus.MUX_Channel_Out), 64'(ch));
        chk({tag, ".valid"}, 64'(bus.MUX_Valid_Out),   64'(v));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        // Inputs active during reset: ack must still stay low.
        bus.Enable_In  = 1'b1;
        bus.Mode_In    = 1'b1;
        bus.Select_In  = 3'd0;
        bus.Data_In    = {8'h14, 8'hA5, 8'h12, 8'h11, 8'h10};
        bus.Valid_In   = 5'b11111;
        bus.Ready_In   = 1'b1;
        bus2.Enable_In = 1'b0;
        bus2.Mode_In   = 1'b1;
        bus2.Select_In = 5'd0;
        bus2.Data_In   = 32'hAAAA_AAAA;
        bus2.Valid_In  = '0;
        bus2.Ready_In  = 1'b1;

        #3;
        chk_out("reset", 8'h00, 3'd0, 1'b0);
        chk("reset.sel_err", 64'(bus.Sel_Err_Out), 64'd0);
        chk("reset.ack",     64'(bus.Ack_Out),     64'd0);
        bus.Enable_In = 1'b0;
        bus.Valid_In  = 5'b00000;
        #9 rst_n = 1'b1;

        // MANUAL load of channel 3.
        tick();
        bus.Enable_In = 1'b1;
        bus.Mode_In   = 1'b0;
        bus.Select_In = 3'd3;
        bus.Valid_In  = 5'b01000;
        #1;
        chk("man.ack", 64'(bus.Ack_Out), 64'b01000);
        tick();
        chk_out("man", 8'hA5, 3'd3, 1'b1);
        bus.Valid_In = 5'b00000;
        #1;
        chk("man.ack_after", 64'(bus.Ack_Out), 64'd0);
        tick();
        chk("man.drained", 64'(bus.MUX_Valid_Out), 64'd0);

        // SCAN with all channels valid: 0,1,2,3,4,0 at one word per cycle.
        bus.Mode_In  = 1'b1;
        bus.Data_In  = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        bus.Valid_In = 5'b11111;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("scan.ack", 64'(bus.Ack_Out), 64'(1) << (i % 5));
            tick();
            chk_out("scan", 8'h10 + 8'(i % 5), 3'(i % 5), 1'b1);
        end

        // Backpressure: hold channel 0 word for 4 cycles, then consume+reload channel 1.
        bus.Ready_In = 1'b0;
        #1;
        chk("bp.ack", 64'(bus.Ack_Out), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out("bp.hold", 8'h10, 3'd0, 1'b1);
            chk("bp.hold_ack", 64'(bus.Ack_Out), 64'd0);
        end
        bus.Ready_In = 1'b1;
        #1;
        chk("bp.release_ack", 64'(bus.Ack_Out), 64'b00010);
        tick();
        chk_out("bp.reload", 8'h11, 3'd1, 1'b1);

        // Out-of-range MANUAL select.
        bus.Valid_In = 5'b00000;
        tick();
        chk("oor.drain", 64'(bus.MUX_Valid_Out), 64'd0);
        bus.Mode_In   = 1'b0;
        bus.Select_In = 3'd6;
        bus.Valid_In  = 5'b11111;
        #1;
        chk("oor.ack", 64'(bus.Ack_Out), 64'd0);
        tick();
        chk("oor.sel_err", 64'(bus.Sel_Err_Out),   64'd1);
        chk("oor.valid",   64'(bus.MUX_Valid_Out), 64'd0);
        bus.Valid_In  = 5'b00000;
        bus.Select_In = 3'd2;
        tick();
        chk("oor.sel_err_end", 64'(bus.Sel_Err_Out),   64'd0);
        chk("oor.valid_end",   64'(bus.MUX_Valid_Out), 64'd0);

        // Reset while FULL (pointer is 2 here, channel 2 loaded -> pointer 3).
        bus.Mode_In  = 1'b1;
        bus.Valid_In = 5'b00100;
        #1;
        chk("rst.pre_ack", 64'(bus.Ack_Out), 64'b00100);
        tick();
        chk_out("rst.pre", 8'h12, 3'd2, 1'b1);
        bus.Valid_In = 5'b00000;
        bus.Ready_In = 1'b0;
        #2;
        rst_n        = 1'b0;
        bus.Valid_In = 5'b11111;
        bus.Ready_In = 1'b1;
        #1;
        chk_out("rst.mid", 8'h00, 3'd0, 1'b0);
        chk("rst.mid_ack", 64'(bus.Ack_Out), 64'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("rst.restart_ack", 64'(bus.Ack_Out), 64'b00001);
        tick();
        chk_out("rst.restart", 8'h10, 3'd0, 1'b1);

        // Enable low while FULL and ready: word drains, no further loads.
        bus.Enable_In = 1'b0;
        #1;
        chk("en.ack", 64'(bus.Ack_Out), 64'd0);
        tick();
        chk("en.drain", 64'(bus.MUX_Valid_Out), 64'd0);
        tick();
        chk("en.idle_valid", 64'(bus.MUX_Valid_Out), 64'd0);
        chk("en.idle_ack",   64'(bus.Ack_Out),       64'd0);
        bus.Enable_In = 1'b1;
        #1;
        chk("en.resume_ack", 64'(bus.Ack_Out), 64'b00010);
        tick();
        chk_out("en.resume", 8'h11, 3'd1, 1'b1);
        bus.Enable_In = 1'b0;

        // 32-channel, 1-bit instance: full scan with wrap 31 -> 0, then MANUAL select 31.
        bus2.Enable_In = 1'b1;
        bus2.Valid_In  = '1;
        #1;
        for (int i = 0; i < 33; i++) begin
            chk("n32.ack", 64'(bus2.Ack_Out), 64'(1) << (i % 32));
            tick();
            chk("n32.chan",  64'(bus2.MUX_Channel_Out), 64'(i % 32));
            chk("n32.data",  64'(bus2.MUX_Data_Out),    64'(i % 2));
            chk("n32.valid", 64'(bus2.MUX_Valid_Out),   64'd1);
        end
        bus2.Mode_In   = 1'b0;
        bus2.Select_In = 5'd31;
        #1;
        chk("n32.man_ack", 64'(bus2.Ack_Out), 64'h8000_0000);
        tick();
        chk("n32.man_chan",    64'(bus2.MUX_Channel_Out), 64'd31);
        chk("n32.man_data",    64'(bus2.MUX_Data_Out),    64'd1);
        chk("n32.man_sel_err", 64'(bus2.Sel_Err_Out),     64'd0);
        bus2.Enable_In = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_n_1_arb
